i2s_rx_ctrl: RTL and testbench
==============================

// Module: i2s_rx_ctrl
// PURPOSE
//  Sequences I2S microphone capture. Enables i2s_clock_gen, discards WARMUP_FRAMES start-up frames,
//  then deserialises sd_i into left/right sample pairs. Delivers each pair on a valid/ready port
//  with a one-deep holding register and overflow signalling.
//  Sits between i2s_clock_gen and the audio DSP/FIFO.
// PARAMETERS
//  SCKS_PER_FRAME  64  SCK periods per WS frame; must match i2s_clock_gen
//  DATA_W          24  sample width; elaboration error unless 1 <= DATA_W <= SCKS_PER_FRAME/2-1
//  WARMUP_FRAMES   2   frames discarded after enable; 0 = start capture on first frame_start_i
//  WS_POL          0   ws_i level denoting left slot
// PORTS
//  clk_i           in   1         system clock; one clock domain
//  rst_i           in   1         synchronous, active-high reset
//  enable_i        in   1         level: capture requested
//  sck_i           in   1         SCK from i2s_clock_gen (registered in clk_i domain)
//  ws_i            in   1         WS from i2s_clock_gen
//  frame_start_i   in   1         1-cycle pulse at start of left slot
//  sd_i            in   1         serial data from microphone
//  clk_gen_en_o    out  1         enable to i2s_clock_gen
//  busy_o          out  1         state != IDLE
//  sample_l_o      out  DATA_W    left sample, signed two's complement, MSB first on wire
//  sample_r_o      out  DATA_W    right sample
//  sample_valid_o  out  1         pair held in output register
//  sample_ready_i  in   1         consumer accepts pair when valid&&ready
//  overflow_o      out  1         1-cycle pulse: new pair dropped
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters, shift register and slot flags cleared.
//  States: IDLE -> WARMUP -> RUN -> STOP -> IDLE.
//  - IDLE: clk_gen_en_o=0. Next cycle after enable_i=1: WARMUP, frame count=0.
//  - WARMUP: clk_gen_en_o=1. Each frame_start_i increments the count.
//    A frame_start_i arriving with count==WARMUP_FRAMES moves to RUN; that frame is captured.
//    enable_i=0 -> IDLE next cycle.
//  - RUN: capture active. enable_i=0 -> STOP.
//  - STOP: capture continues. Next frame_start_i -> IDLE.
//    enable_i=1 again -> RUN with no gap in capture.
//  SCK rise = sck_i & ~sck_q. On each rise, sample ws_i and sd_i:
//  - ws changed since previous rise: bit_idx=0 (I2S delay bit, discarded).
//  - otherwise bit_idx++ (saturating).
//  - bit_idx 1..DATA_W: shift sd_i in MSB first.
//  - bit_idx==DATA_W: latch word into left or right staging per sampled ws; set slot flag.
//  - Bits beyond DATA_W are ignored.
//  Entering RUN, and each frame_start_i, clears both slot flags.
//  A pair is pushed only when both flags are set.
//  Push happens the clk after the right word's DATA_W-th bit is sampled.
//  Output register, on push:
//  - empty, or valid&&ready in the same cycle: load; valid=1.
//  - else: keep the old pair and pulse overflow_o.
//  - valid&&ready without push: valid=0 next cycle.
//  Partial frame on leaving RUN/STOP to IDLE: discarded, no push.
//  The held pair stays valid across IDLE until it is consumed.
//  rst_i mid-frame: immediate return to reset state; the held pair is lost.
// CONFIGURATION
//  I2S_RX_OVF_CNT_EN defined:
//  - adds port ovf_count_o (16-bit): count of dropped pairs, saturating at 16'hFFFF.
//  - counter is cleared by rst_i and on the IDLE->WARMUP transition.
//  Undefined: port absent; overflow_o is still generated.
// STRUCTURE
//  i2s_pkg:
//  - typedef enum logic [1:0] i2s_rx_state_e {RX_IDLE, RX_WARMUP, RX_RUN, RX_STOP}.
//  - localparams for the bit_idx width and frame-count width.
//  Sub-module i2s_slot_shifter:
//  - SCK edge detect, ws change detect, bit_idx, shift register.
//  - outputs word_done pulse + word + slot.
//  i2s_rx_ctrl owns the FSM, slot flags, output register and overflow logic.
// TESTING
//  Bench drives i2s_clock_gen (SCK_DIV=8, 64 SCK/frame) plus a behavioural mic model.
//  1. Reset, then enable_i=1, WARMUP_FRAMES=2, mic L=24'h123456, R=24'hABCDEF
//     -> clk_gen_en_o=1 next cycle; no valid during frames 0-1;
//     first pair L=123456/R=ABCDEF in frame 2, ~1024 clk per pair thereafter.
//  2. sample_ready_i=0 for 3 frames
//     -> first pair held unchanged; overflow_o pulses 2 times;
//     ovf_count_o=2 with I2S_RX_OVF_CNT_EN.
//  3. ready asserted on the exact cycle of the next push
//     -> old pair accepted, new pair loaded, valid stays 1, no overflow.
//  4. enable_i=0 mid-left-slot in RUN
//     -> current frame's pair delivered; IDLE and clk_gen_en_o=0 at next frame_start_i.
//  5. enable_i toggled 1->0 during WARMUP
//     -> IDLE next cycle, no sample_valid_o.
//  6. rst_i pulsed mid-right-slot with valid=1
//     -> all outputs 0 next cycle; no push from the partial frame.
//  Negative-number check: L=24'h800000, R=24'h7FFFFF captured bit-exact.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: receive-path state type plus bit-index and warm-up frame-counter widths
package i2s_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_WARMUP, RX_RUN, RX_STOP} i2s_rx_state_e;
  localparam int BIT_IDX_W = 8;
  localparam int FRM_CNT_W = 8;
endpackage

// File: rtl/i2s_slot_shifter.sv
// i2s_slot_shifter: SCK rise detect, WS change detect, saturating bit_idx, MSB-first shift; in clk_i/rst_i/sck_i/ws_i/sd_i, out word_done_o pulse, word_o, slot_o (ws level of the word)
module i2s_slot_shifter import i2s_pkg::*; #(
  parameter int DATA_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sck_i,
  input  logic              ws_i,
  input  logic              sd_i,
  output logic              word_done_o,
  output logic [DATA_W-1:0] word_o,
  output logic              slot_o
);
  logic sck_q, ws_q, rise;
  logic [BIT_IDX_W-1:0] bit_idx, idx_n;
  assign rise = sck_i & ~sck_q;
  always_comb idx_n = (ws_i != ws_q) ? '0 : (&bit_idx ? bit_idx : bit_idx + 1'b1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      bit_idx     <= '0;
      word_o      <= '0;
      word_done_o <= 1'b0;
      slot_o      <= 1'b0;
    end else begin
      sck_q       <= sck_i;
      word_done_o <= rise && idx_n == BIT_IDX_W'(DATA_W);
      if (rise) begin
        ws_q    <= ws_i;
        bit_idx <= idx_n;
        if (idx_n != '0 && idx_n <= BIT_IDX_W'(DATA_W)) word_o <= (word_o << 1) | DATA_W'(sd_i);
        if (idx_n == BIT_IDX_W'(DATA_W)) slot_o <= ws_i;
      end
    end
  end
endmodule

// File: rtl/i2s_rx_ctrl.sv
// i2s_rx_ctrl: I2S mic capture sequencer; in clk_i/rst_i/enable_i/sck_i/ws_i/frame_start_i/sd_i/sample_ready_i, out clk_gen_en_o/busy_o/sample_l_o/sample_r_o/sample_valid_o/overflow_o; I2S_RX_OVF_CNT_EN adds ovf_count_o
module i2s_rx_ctrl import i2s_pkg::*; #(
  parameter int   SCKS_PER_FRAME = 64,
  parameter int   DATA_W         = 24,
  parameter int   WARMUP_FRAMES  = 2,
  parameter logic WS_POL         = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              sck_i,
  input  logic              ws_i,
  input  logic              frame_start_i,
  input  logic              sd_i,
  output logic              clk_gen_en_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] sample_l_o,
  output logic [DATA_W-1:0] sample_r_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic              overflow_o
`ifdef I2S_RX_OVF_CNT_EN
  ,output logic [15:0]      ovf_count_o
`endif
);
  if (DATA_W < 1 || DATA_W > SCKS_PER_FRAME / 2 - 1) begin : g_bad_width
    $error("i2s_rx_ctrl: DATA_W must be within 1..SCKS_PER_FRAME/2-1");
  end
  if (SCKS_PER_FRAME / 2 >= 2 ** BIT_IDX_W || WARMUP_FRAMES >= 2 ** FRM_CNT_W) begin : g_bad_range
    $error("i2s_rx_ctrl: SCKS_PER_FRAME or WARMUP_FRAMES exceeds counter width");
  end
  i2s_rx_state_e state, state_n;
  logic [FRM_CNT_W-1:0] frm_cnt;
  logic [DATA_W-1:0] word, l_stage, r_stage;
  logic word_done, slot, word_left, capture, enter_run, push, drop, l_flag, r_flag;
  i2s_slot_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk_i(clk_i), .rst_i(rst_i), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
    .word_done_o(word_done), .word_o(word), .slot_o(slot)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= RX_IDLE;
      frm_cnt <= '0;
    end else begin
      state   <= state_n;
      frm_cnt <= state == RX_IDLE ? '0 : (state == RX_WARMUP && frame_start_i) ? frm_cnt + 1'b1 : frm_cnt;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      RX_IDLE:   if (enable_i) state_n = RX_WARMUP;
      RX_WARMUP: if (!enable_i) state_n = RX_IDLE;
                 else if (frame_start_i && frm_cnt == FRM_CNT_W'(WARMUP_FRAMES)) state_n = RX_RUN;
      RX_RUN:    if (!enable_i) state_n = RX_STOP;
      RX_STOP:   if (enable_i) state_n = RX_RUN;
                 else if (frame_start_i) state_n = RX_IDLE;
      default:   state_n = RX_IDLE;
    endcase
  end
  always_comb begin
    clk_gen_en_o = state != RX_IDLE;
    busy_o       = state != RX_IDLE;
    capture      = state == RX_RUN || state == RX_STOP;
  end
  // The word that completes the pair goes straight into the output register so the
  // push lands one clock after its last bit was sampled.
  assign word_left = slot == WS_POL;
  assign enter_run = state == RX_WARMUP && state_n == RX_RUN;
  assign push      = capture && word_done && (word_left ? r_flag : l_flag);
  assign drop      = push && sample_valid_o && !sample_ready_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      l_flag         <= 1'b0;
      r_flag         <= 1'b0;
      l_stage        <= '0;
      r_stage        <= '0;
      sample_l_o     <= '0;
      sample_r_o     <= '0;
      sample_valid_o <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      l_flag     <= ~(enter_run | frame_start_i) & l_flag | capture & word_done & word_left;
      r_flag     <= ~(enter_run | frame_start_i) & r_flag | capture & word_done & ~word_left;
      overflow_o <= drop;
      if (capture && word_done && word_left) l_stage <= word;
      if (capture && word_done && !word_left) r_stage <= word;
      if (push && (!sample_valid_o || sample_ready_i)) begin
        sample_l_o     <= word_left ? word : l_stage;
        sample_r_o     <= word_left ? r_stage : word;
        sample_valid_o <= 1'b1;
      end else if (sample_valid_o && sample_ready_i) begin
        sample_valid_o <= 1'b0;
      end
    end
  end
`ifdef I2S_RX_OVF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || (state == RX_IDLE && state_n == RX_WARMUP)) ovf_count_o <= '0;
    else if (drop && ~&ovf_count_o) ovf_count_o <= ovf_count_o + 1'b1;
  end
`endif
endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// tb_i2s_rx_ctrl: directed checks of i2s_rx_ctrl driven by a 64-SCK/frame clock-gen and mic model (SCK = clk/16)
module tb_i2s_rx_ctrl;
  logic clk_i = 1'b0;
  logic rst_i, enable_i, sample_ready_i;
  logic sck, ws, sd, frame_start;
  logic clk_gen_en, busy, sample_valid, overflow;
  logic [23:0] sample_l, sample_r, mic_l, mic_r;
`ifdef I2S_RX_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif
  logic [2:0] div;
  logic [5:0] pos, np;
  int cyc = 0, total = 0, bad = 0, fs_seen = 0, ovf_seen = 0, last_ovf = 0, t1, q;
  logic seen;
  i2s_rx_ctrl #(.SCKS_PER_FRAME(64), .DATA_W(24), .WARMUP_FRAMES(2), .WS_POL(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .sck_i(sck), .ws_i(ws),
    .frame_start_i(frame_start), .sd_i(sd), .clk_gen_en_o(clk_gen_en), .busy_o(busy),
    .sample_l_o(sample_l), .sample_r_o(sample_r), .sample_valid_o(sample_valid),
    .sample_ready_i(sample_ready_i), .overflow_o(overflow)
`ifdef I2S_RX_OVF_CNT_EN
    , .ovf_count_o(ovf_count)
`endif
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  assign np = pos + 6'd1;
  function automatic logic mic_bit(input logic [5:0] p);
    logic [23:0] w;
    int b;
    w = p[5] ? mic_r : mic_l;
    b = int'(p[4:0]);
    return (b >= 1 && b <= 24) ? w[24-b] : 1'b0;
  endfunction
  always @(posedge clk_i) begin
    frame_start <= 1'b0;
    if (rst_i || !clk_gen_en) begin
      div <= '0; sck <= 1'b1; pos <= 6'd63; ws <= 1'b1; sd <= 1'b0;
    end else begin
      div <= div + 3'd1;
      if (div == 3'd7) begin
        sck <= ~sck;
        if (sck) begin
          pos <= np; ws <= np[5]; frame_start <= np == 6'd0; sd <= mic_bit(np);
        end
      end
    end
  end
  always @(negedge clk_i) begin
    if (overflow) begin ovf_seen++; last_ovf = cyc; end
    if (frame_start) fs_seen++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask
  task automatic wait_valid(input int budget);
    int n = 0;
    while (!sample_valid && n < budget) begin tick(1); n++; end
    chk("valid_wait", 32'(sample_valid), 32'd1);
  endtask
  task automatic wait_fs(input int budget);
    int n = 0;
    while (!frame_start && n < budget) begin tick(1); n++; end
    chk("fs_wait", 32'(frame_start), 32'd1);
  endtask
  initial begin
    rst_i = 1'b1; enable_i = 1'b0; sample_ready_i = 1'b0;
    mic_l = 24'h123456; mic_r = 24'hABCDEF;
    tick(3); rst_i = 1'b0; tick(1);
    chk("rst_clk_en", 32'(clk_gen_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_l", 32'(sample_l), 32'd0);
    chk("rst_r", 32'(sample_r), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    fs_seen = 0; enable_i = 1'b1; tick(1);
    chk("t1_clk_en", 32'(clk_gen_en), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_valid(4000);
    chk("t1_warmup_frames", 32'(fs_seen), 32'd3);
    chk("t1_l", 32'(sample_l), 32'h123456);
    chk("t1_r", 32'(sample_r), 32'hABCDEF);
    t1 = cyc; sample_ready_i = 1'b1; tick(1); sample_ready_i = 1'b0;
    chk("t1_consume", 32'(sample_valid), 32'd0);
    wait_valid(1100);
    chk("t1_period", 32'(cyc - t1), 32'd1024);
    chk("t1_l2", 32'(sample_l), 32'h123456);
    chk("t1_r2", 32'(sample_r), 32'hABCDEF);
    mic_l = 24'h800000; mic_r = 24'h7FFFFF; ovf_seen = 0;
    tick(2048 + 20);
    chk("t2_ovf_pulses", 32'(ovf_seen), 32'd2);
    chk("t2_valid", 32'(sample_valid), 32'd1);
    chk("t2_l_held", 32'(sample_l), 32'h123456);
    chk("t2_r_held", 32'(sample_r), 32'hABCDEF);
`ifdef I2S_RX_OVF_CNT_EN
    chk("t2_ovf_count", 32'(ovf_count), 32'd2);
`endif
    q = last_ovf + 1024;
    while (cyc < q - 1) tick(1);
    sample_ready_i = 1'b1; tick(1);
    chk("t3_valid", 32'(sample_valid), 32'd1);
    chk("t3_l_neg", 32'(sample_l), 32'h800000);
    chk("t3_r_pos", 32'(sample_r), 32'h7FFFFF);
    chk("t3_no_ovf", 32'(overflow), 32'd0);
    chk("t3_ovf_total", 32'(ovf_seen), 32'd2);
    mic_l = 24'h5A5A5A; mic_r = 24'hA5A5A5; tick(1); sample_ready_i = 1'b0;
    chk("t3_consume", 32'(sample_valid), 32'd0);
    wait_fs(1100); tick(100); enable_i = 1'b0; tick(1);
    chk("t4_stop_busy", 32'(busy), 32'd1);
    chk("t4_stop_clk_en", 32'(clk_gen_en), 32'd1);
    wait_valid(1100);
    chk("t4_l", 32'(sample_l), 32'h5A5A5A);
    chk("t4_r", 32'(sample_r), 32'hA5A5A5);
    wait_fs(1100); tick(1);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_clk_en", 32'(clk_gen_en), 32'd0);
    chk("t4_held_valid", 32'(sample_valid), 32'd1);
    sample_ready_i = 1'b1; tick(1); sample_ready_i = 1'b0;
    enable_i = 1'b1; tick(1);
    chk("t5_busy", 32'(busy), 32'd1);
`ifdef I2S_RX_OVF_CNT_EN
    chk("t5_ovf_count_clr", 32'(ovf_count), 32'd0);
`endif
    tick(50); enable_i = 1'b0; tick(1);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_clk_en", 32'(clk_gen_en), 32'd0);
    seen = 1'b0;
    repeat (3000) begin tick(1); if (sample_valid) seen = 1'b1; end
    chk("t5_no_valid", 32'(seen), 32'd0);
    enable_i = 1'b1;
    wait_valid(4000);
    chk("t6_l", 32'(sample_l), 32'h5A5A5A);
    wait_fs(1100); tick(612);
    chk("t6_valid_before", 32'(sample_valid), 32'd1);
    rst_i = 1'b1; enable_i = 1'b0; tick(1); rst_i = 1'b0;
    chk("t6_valid", 32'(sample_valid), 32'd0);
    chk("t6_l0", 32'(sample_l), 32'd0);
    chk("t6_r0", 32'(sample_r), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_clk_en", 32'(clk_gen_en), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
`ifdef I2S_RX_OVF_CNT_EN
    chk("t6_ovf_count", 32'(ovf_count), 32'd0);
`endif
    seen = 1'b0;
    repeat (400) begin tick(1); if (sample_valid) seen = 1'b1; end
    chk("t6_no_push", 32'(seen), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
